// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl -- iteration scheduler for the LDPC decoder datapath.
//
// Loads one LLR frame, then runs flooding iterations (CNU phase, CNU drain,
// VNU phase, VNU drain, syndrome check). It stops on a zero syndrome or on
// the iteration limit and then unloads the decoded frame. The block only
// sequences the shared group address and the phase enables.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid_i     LLR word present        in_ready_o   LLR word accepted
//   llr_we_o       LLR memory write at addr_o
//   cnu_en_o       CNU group issue         vnu_en_o     VNU group issue
//   addr_o         shared group address
//   syn_ok_i       syndrome-zero flag, sampled in CHECK only
//   out_valid_o    decoded word at addr_o  out_ready_i  sink accepts word
//   iter_cnt_o     completed iterations    converged_o  ended on syn_ok
//   busy_o         any state except IDLE
module ldpc_iter_ctrl #(
   parameter int ADDR_N   = 6,
   parameter int ADDR_W   = 3,
   parameter int CNU_LAT  = 2,
   parameter int VNU_LAT  = 3,
   parameter int MAX_ITER = 20,
   parameter int ITER_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              llr_we_o,
   output logic              cnu_en_o,
   output logic              vnu_en_o,
   output logic [ADDR_W-1:0] addr_o,
   input  logic              syn_ok_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ITER_W-1:0] iter_cnt_o,
   output logic              converged_o,
   output logic              busy_o
);

   localparam int LAT_MAX = (CNU_LAT > VNU_LAT) ? CNU_LAT : VNU_LAT;
   localparam int DRN_W   = $clog2(LAT_MAX + 1);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_N - 1);
   localparam logic [DRN_W-1:0]  CDRN_LAST = DRN_W'(CNU_LAT - 1);
   localparam logic [DRN_W-1:0]  VDRN_LAST = DRN_W'(VNU_LAT - 1);
   localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CNU, S_CDRN, S_VNU, S_VDRN, S_CHECK, S_OUT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [DRN_W-1:0]  drn_q, drn_d;
   logic              conv_q, conv_d;
   logic              addr_last;

   assign addr_last = (addr_q == ADDR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         iter_q  <= '0;
         drn_q   <= '0;
         conv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         iter_q  <= iter_d;
         drn_q   <= drn_d;
         conv_q  <= conv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      iter_d  = iter_q;
      drn_d   = drn_q;
      conv_d  = conv_q;
      case (state_q)
         // IDLE always has addr 0, so its first accept writes word 0.
         S_IDLE: begin
            if (in_valid_i) begin
               addr_d  = ADDR_W'(1);
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid_i) begin
               if (addr_last) begin
                  addr_d  = '0;
                  state_d = S_CNU;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         S_CNU: begin
            if (addr_last) begin
               addr_d  = '0;
               state_d = S_CDRN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_CDRN: begin
            if (drn_q == CDRN_LAST) begin
               drn_d   = '0;
               state_d = S_VNU;
            end else begin
               drn_d = drn_q + 1'b1;
            end
         end
         S_VNU: begin
            if (addr_last) begin
               addr_d  = '0;
               state_d = S_VDRN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         // The iteration is counted when the VNU pipe has drained, so CHECK
         // compares against the already-incremented count.
         S_VDRN: begin
            if (drn_q == VDRN_LAST) begin
               drn_d   = '0;
               iter_d  = iter_q + 1'b1;
               state_d = S_CHECK;
            end else begin
               drn_d = drn_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (syn_ok_i) begin
               conv_d  = 1'b1;
               state_d = S_OUT;
            end else if (iter_q == ITER_MAX) begin
               conv_d  = 1'b0;
               state_d = S_OUT;
            end else begin
               state_d = S_CNU;
            end
         end
         S_OUT: begin
            if (out_ready_i) begin
               if (addr_last) begin
                  addr_d  = '0;
                  iter_d  = '0;
                  conv_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready_o  = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign llr_we_o    = in_valid_i && in_ready_o;
   assign cnu_en_o    = (state_q == S_CNU);
   assign vnu_en_o    = (state_q == S_VNU);
   assign out_valid_o = (state_q == S_OUT);
   assign busy_o      = (state_q != S_IDLE);
   assign addr_o      = addr_q;
   assign iter_cnt_o  = iter_q;
   assign converged_o = conv_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl (default parameters: 6 groups, CNU
// drain 2, VNU drain 3, 20 iterations -> 18 cycles per iteration).
module tb_ldpc_iter_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       syn_ok = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, llr_we, cnu_en, vnu_en, out_valid, converged, busy;
   logic [2:0] addr;
   logic [4:0] iter_cnt;

   int n_chk = 0;
   int n_pass = 0;

   ldpc_iter_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .llr_we_o    (llr_we),
      .cnu_en_o    (cnu_en),
      .vnu_en_o    (vnu_en),
      .addr_o      (addr),
      .syn_ok_i    (syn_ok),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .iter_cnt_o  (iter_cnt),
      .converged_o (converged),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Loads 6 words; gaps=1 uses in_valid pattern 1,0,1,1,0 repeating.
   // Returns positioned in the first CNU cycle.
   task automatic load(input bit gaps);
      int k = 0;
      for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
         in_valid = gaps ? ((cyc % 5) == 0 || (cyc % 5) == 2 || (cyc % 5) == 3) : 1'b1;
         #1;
         chk($sformatf("ld_addr_c%0d", cyc), 32'(addr), 32'(k));
         chk($sformatf("ld_we_c%0d", cyc), 32'(llr_we), 32'(in_valid));
         chk($sformatf("ld_rdy_c%0d", cyc), 32'(in_ready), 32'd1);
         if (in_valid) k++;
         step();
      end
      if (k != 6) chk("ld_timeout", 32'(k), 32'd6);
      chk("ld_done_rdy", 32'(in_ready), 32'd0);
   endtask

   // One iteration, 18 cycles from first CNU cycle through CHECK.
   // syn_ok is held 1 outside CHECK to show it is ignored there.
   task automatic sweep(input int it, input bit syn);
      logic [7:0] obs, exp;
      bit         ec, ev;
      int         ea;
      for (int c = 0; c < 18; c++) begin
         ec = (c < 6);
         ev = (c >= 8 && c < 14);
         ea = ec ? c : (ev ? c - 8 : 0);
         syn_ok = (c == 17) ? syn : 1'b1;
         obs = {llr_we, cnu_en, vnu_en, busy, out_valid, addr};
         exp = {1'b0, ec, ev, 1'b1, 1'b0, 3'(ea)};
         chk($sformatf("sw%0d_c%0d", it, c), 32'(obs), 32'(exp));
         chk($sformatf("sw%0d_c%0d_iter", it, c), 32'(iter_cnt), (c == 17) ? 32'(it) : 32'(it - 1));
         step();
      end
      syn_ok = 1'b0;
   endtask

   // Unload 6 words; toggle=1 drives out_ready 0,1,0,1,...
   task automatic unload(input int it, input bit conv, input bit toggle);
      int k = 0;
      for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
         out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
         chk($sformatf("out_vld_c%0d", cyc), 32'({out_valid, busy, llr_we}), 32'b110);
         chk($sformatf("out_addr_c%0d", cyc), 32'(addr), 32'(k));
         chk($sformatf("out_stat_c%0d", cyc), 32'({converged, iter_cnt}), 32'({conv, 5'(it)}));
         if (out_ready) k++;
         step();
      end
      if (k != 6) chk("out_timeout", 32'(k), 32'd6);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      #1;
      chk("idle_after_out", 32'({in_ready, busy, out_valid, addr, iter_cnt, converged}),
          32'({1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_vals", 32'({in_ready, busy, addr, iter_cnt, converged}), 32'({1'b1, 1'b0, 3'd0, 5'd0, 1'b0}));
      chk("rst_en", 32'({llr_we, cnu_en, vnu_en, out_valid}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // A: continuous load, converge on first CHECK, out_valid at t+19.
      load(1'b0);
      sweep(1, 1'b1);
      unload(1, 1'b1, 1'b0);

      // B: syn_ok never set -> 20 iterations, not converged.
      load(1'b0);
      for (int i = 1; i <= 20; i++) sweep(i, 1'b0);
      unload(20, 1'b0, 1'b0);

      // C: syn_ok at the 20th CHECK wins over the limit.
      load(1'b0);
      for (int i = 1; i <= 19; i++) sweep(i, 1'b0);
      sweep(20, 1'b1);
      unload(20, 1'b1, 1'b0);

      // D: gapped load and backpressured unload.
      load(1'b1);
      sweep(1, 1'b0);
      sweep(2, 1'b1);
      unload(2, 1'b1, 1'b1);

      // E: reset during VNU at addr 3, then a normal frame.
      load(1'b0);
      in_valid = 1'b0;
      repeat (11) step();
      chk("pre_rst_vnu", 32'({vnu_en, addr}), 32'({1'b1, 3'd3}));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst", 32'({vnu_en, addr, busy, in_ready, iter_cnt}),
          32'({1'b0, 3'd0, 1'b0, 1'b1, 5'd0}));
      step();
      rst_n = 1'b1;
      load(1'b0);
      sweep(1, 1'b1);
      unload(1, 1'b1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
